// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU, single-cycle logic/shift ops, Booth MUL, restoring signed DIV when SEQ_ALU_DIV_EN is defined
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   input_a,
  input  logic [WIDTH-1:0]   input_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] ALU_result,
  output logic               div_by_zero,
  output logic               illegal_op
);
  localparam int SW = $clog2(WIDTH);
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, FIN} state_t;
  state_t state, state_n;
  logic [4:0] op;
  logic [WIDTH-1:0] a, b, simple, load;
  logic [2*WIDTH+1:0] acc, acc_n;
  logic [WIDTH:0] upper, sum;
  logic [SW:0] cnt;
  logic [SW-1:0] sh;
  logic [2*WIDTH-1:0] res_n;
  logic accept, last, dz_n, ill_n;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0] a_mag, b_mag, q, r;
  logic [WIDTH:0] shifted, trial;
`endif
  assign busy = state != IDLE;
  assign accept = state == IDLE && start;
  assign last = cnt == (SW+1)'(WIDTH);
  assign sh = b[SW-1:0];
  always_comb begin
    case (op)
      5'd0: simple = a + b;
      5'd1: simple = a - b;
      5'd2: simple = a & b;
      5'd3: simple = a | b;
      5'd4: simple = a >> sh;
      5'd5: simple = $signed(a) >>> sh;
      5'd6: simple = a << sh;
      5'd7: simple = (a >> sh) | (a << (WIDTH - int'(sh)));
      5'd8: simple = (a << sh) | (a >> (WIDTH - int'(sh)));
      5'd9: simple = -a;
      5'd12: simple = ~a;
      default: simple = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = opcode == 5'd10 ? MUL : DIV_EN && opcode == 5'd11 && |input_b ? DIV : EXEC;
      MUL, DIV: if (last) state_n = FIN;
      default: state_n = IDLE;
    endcase
  end
  // acc layout shared by both iterators: {upper/remainder[W:0], multiplier/quotient[W-1:0], booth_q_minus_1}
  always_comb begin
    upper = acc[2*WIDTH+1:WIDTH+1];
    sum = acc[1:0] == 2'b01 ? upper + {a[WIDTH-1], a} : acc[1:0] == 2'b10 ? upper - {a[WIDTH-1], a} : upper;
`ifdef SEQ_ALU_DIV_EN
    a_mag = input_a[WIDTH-1] ? -input_a : input_a;
    b_mag = b[WIDTH-1] ? -b : b;
    shifted = {acc[2*WIDTH:WIDTH+1], acc[WIDTH]};
    trial = shifted - {1'b0, b_mag};
    q = a[WIDTH-1] ^ b[WIDTH-1] ? -acc[WIDTH:1] : acc[WIDTH:1];
    r = a[WIDTH-1] ? -acc[2*WIDTH:WIDTH+1] : acc[2*WIDTH:WIDTH+1];
    load = opcode == 5'd10 ? input_b : a_mag;
`else
    load = input_b;
`endif
    acc_n = accept ? {{(WIDTH+1){1'b0}}, load, 1'b0} : state == MUL && !last ? {sum[WIDTH], sum, acc[WIDTH:1]} : acc;
`ifdef SEQ_ALU_DIV_EN
    if (state == DIV) acc_n = last ? {1'b0, r, q, 1'b0} : {trial[WIDTH] ? shifted : trial, acc[WIDTH-1:1], ~trial[WIDTH], 1'b0};
`endif
  end
  always_comb begin
    ill_n = state == EXEC && !(op <= 5'd9 || op == 5'd12 || DIV_EN && op == 5'd11);
    dz_n = state == EXEC && DIV_EN && op == 5'd11;
    res_n = ill_n ? '0 : dz_n ? {a, {WIDTH{1'b1}}} : state == FIN ? acc[2*WIDTH:1] : {{WIDTH{1'b0}}, simple};
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      done <= 1'b0;
      ALU_result <= '0;
      div_by_zero <= 1'b0;
      illegal_op <= 1'b0;
      op <= '0;
      a <= '0;
      b <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      done <= state == EXEC || state == FIN;
      if (state == EXEC || state == FIN) begin
        ALU_result <= res_n;
        div_by_zero <= dz_n;
        illegal_op <= ill_n;
      end
      if (accept) begin
        op <= opcode;
        a <= input_a;
        b <= input_b;
      end
      acc <= acc_n;
      cnt <= state == MUL || state == DIV ? cnt + (SW+1)'(1) : '0;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven, hand-sequenced and randomized self-checking bench for seq_alu
module tb_seq_alu;
  localparam int W = 32;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic clear, start, busy, done, div_by_zero, illegal_op;
  logic [4:0] opcode;
  logic [W-1:0] input_a, input_b;
  logic [2*W-1:0] ALU_result;
  int nvec = 0;
  int nerr = 0;
  typedef struct {
    logic [4:0] op;
    logic [W-1:0] a, b;
    logic [2*W-1:0] res;
    logic dz, ill;
    int lat;
  } vec_t;
  vec_t vecs[$];
  seq_alu #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .input_a(input_a), .input_b(input_b), .busy(busy), .done(done),
    .ALU_result(ALU_result), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );
  always #5 clock = ~clock;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic add(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2*W-1:0] res, input logic dz, input logic ill, input int lat);
    vecs.push_back('{op, a, b, res, dz, ill, lat});
  endtask
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  function automatic void model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [2*W-1:0] res, output logic dz, output logic ill, output int lat);
    longint sa, sb;
    logic [W-1:0] lo;
    int sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b % W);
    lo = '0;
    res = '0;
    dz = 1'b0;
    ill = 1'b0;
    lat = 1;
    case (op)
      5'd0: lo = a + b;
      5'd1: lo = a - b;
      5'd2: lo = a & b;
      5'd3: lo = a | b;
      5'd4: lo = a >> sh;
      5'd5: lo = W'(sa >>> sh);
      5'd6: lo = a << sh;
      5'd7: begin lo = a; repeat (sh) lo = {lo[0], lo[W-1:1]}; end
      5'd8: begin lo = a; repeat (sh) lo = {lo[W-2:0], lo[W-1]}; end
      5'd9: lo = W'(-sa);
      5'd12: lo = ~a;
      5'd10: begin res = (2*W)'(sa * sb); lat = W + 2; end
      5'd11: begin
        if (!DIV_EN) ill = 1'b1;
        else if (b == 0) begin res = {a, {W{1'b1}}}; dz = 1'b1; end
        else begin res = {W'(sa % sb), W'(sa / sb)}; lat = W + 2; end
      end
      default: ill = 1'b1;
    endcase
    if (!ill && op != 5'd10 && op != 5'd11) res = {{W{1'b0}}, lo};
  endfunction
  task automatic apply(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] res, output logic dz, output logic ill, output int lat);
    @(negedge clock);
    start = 1'b1;
    opcode = op;
    input_a = a;
    input_b = b;
    @(posedge clock);
    #1;
    check("busy_after_accept", busy, 1);
    start = 1'b0;
    opcode = 5'($urandom);
    input_a = $urandom;
    input_b = $urandom;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check("busy_low_with_done", busy, 0);
    res = ALU_result;
    dz = div_by_zero;
    ill = illegal_op;
  endtask
  initial begin
    logic [2*W-1:0] res, eres;
    logic dz, ill, edz, eill;
    int lat, elat, pulses;
    logic [4:0] op;
    logic [W-1:0] a, b;
    clear = 1'b1;
    start = 1'b0;
    opcode = '0;
    input_a = '0;
    input_b = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", ALU_result, 0);
    check("reset_dz", div_by_zero, 0);
    check("reset_ill", illegal_op, 0);
    @(negedge clock);
    clear = 1'b0;
    add(5'd0, 32'd2, 32'd3, 64'h5, 1'b0, 1'b0, 1);
    add(5'd1, 32'd2, 32'd3, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1);
    add(5'd10, 32'd12, 32'd17, 64'd204, 1'b0, 1'b0, 34);
    add(5'd10, 32'hFFFF_FFFA, 32'd5, 64'hFFFF_FFFF_FFFF_FFE2, 1'b0, 1'b0, 34);
    add(5'd10, 32'hFFFF_FFEF, 32'hFFFF_FFF7, 64'd153, 1'b0, 1'b0, 34);
    add(5'd10, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 34);
    add(5'd7, 32'd17, 32'd5, 64'h8800_0000, 1'b0, 1'b0, 1);
    add(5'd5, 32'hFFFF_FFEF, 32'd3, 64'hFFFF_FFFD, 1'b0, 1'b0, 1);
    add(5'd8, 32'd17, 32'h25, 64'h220, 1'b0, 1'b0, 1);
    add(5'd2, 32'hF0F0, 32'hFF00, 64'hF000, 1'b0, 1'b0, 1);
    add(5'd3, 32'hF0F0, 32'hFF00, 64'hFFF0, 1'b0, 1'b0, 1);
    add(5'd4, 32'h8000_0000, 32'd31, 64'h1, 1'b0, 1'b0, 1);
    add(5'd6, 32'd1, 32'd31, 64'h8000_0000, 1'b0, 1'b0, 1);
    add(5'd9, 32'd1, 32'd0, 64'hFFFF_FFFF, 1'b0, 1'b0, 1);
    add(5'd12, 32'd0, 32'd5, 64'hFFFF_FFFF, 1'b0, 1'b0, 1);
    add(5'd20, 32'd5, 32'd6, 64'h0, 1'b0, 1'b1, 1);
    add(5'd13, 32'd5, 32'd6, 64'h0, 1'b0, 1'b1, 1);
    add(5'd31, 32'd5, 32'd6, 64'h0, 1'b0, 1'b1, 1);
`ifdef SEQ_ALU_DIV_EN
    add(5'd11, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 64'hFFFF_FFFE_0000_0002, 1'b0, 1'b0, 34);
    add(5'd11, 32'd17, 32'd0, 64'h0000_0011_FFFF_FFFF, 1'b1, 1'b0, 1);
    add(5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 34);
    add(5'd11, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 1'b0, 34);
`else
    add(5'd11, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 64'h0, 1'b0, 1'b1, 1);
    add(5'd11, 32'd17, 32'd0, 64'h0, 1'b0, 1'b1, 1);
`endif
    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b, res, dz, ill, lat);
      check($sformatf("vec%0d_op%0d_res", i, vecs[i].op), res, vecs[i].res);
      check($sformatf("vec%0d_op%0d_dz", i, vecs[i].op), dz, vecs[i].dz);
      check($sformatf("vec%0d_op%0d_ill", i, vecs[i].op), ill, vecs[i].ill);
      check($sformatf("vec%0d_op%0d_lat", i, vecs[i].op), lat, vecs[i].lat);
    end
    @(negedge clock);
    start = 1'b1;
    opcode = 5'd0;
    input_a = 32'd7;
    input_b = 32'd8;
    @(posedge clock);
    pulses = 0;
    repeat (6) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    start = 1'b0;
    check("held_start_pulses", pulses, 3);
    check("held_start_res", ALU_result, 64'd15);
    repeat (3) @(posedge clock);
    @(negedge clock);
    start = 1'b1;
    opcode = 5'd10;
    input_a = 32'd12;
    input_b = 32'd17;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_res", ALU_result, 0);
    check("abort_dz", div_by_zero, 0);
    check("abort_ill", illegal_op, 0);
    @(negedge clock);
    clear = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    op = DIV_EN ? 5'd11 : 5'd10;
    a = DIV_EN ? 32'hFFFF_FFF8 : 32'hFFFF_FFFA;
    b = DIV_EN ? 32'hFFFF_FFFD : 32'd5;
    model(op, a, b, eres, edz, eill, elat);
    @(negedge clock);
    start = 1'b1;
    opcode = op;
    input_a = a;
    input_b = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
      start = lat == 5;
      opcode = 5'd0;
      input_a = 32'd1;
      input_b = 32'd1;
    end
    start = 1'b0;
    check("ignored_start_res", ALU_result, eres);
    check("ignored_start_lat", lat, elat);
    pulses = 0;
    repeat (5) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
    check("ignored_start_no_queue", pulses, 0);
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 7) == 0 ? 5'($urandom_range(13, 31)) : 5'($urandom_range(0, 12));
      a = pick();
      b = $urandom_range(0, 5) == 0 ? '0 : pick();
      model(op, a, b, eres, edz, eill, elat);
      apply(op, a, b, res, dz, ill, lat);
      check($sformatf("rnd%0d_op%0d_a%h_b%h_res", i, op, a, b), res, eres);
      check($sformatf("rnd%0d_op%0d_dz", i, op), dz, edz);
      check($sformatf("rnd%0d_op%0d_ill", i, op), ill, eill);
      check($sformatf("rnd%0d_op%0d_lat", i, op), lat, elat);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
